// File: rtl/fw_loader_pkg.sv
// fw_loader_pkg: shared types and helpers for the firmware loader.
//   state_t        - loader FSM states
//   BYTES_PER_WORD - payload bytes packed into each RAM word
//   len_overflow() - true when a requested word count exceeds the RAM
// Build option: LOADER_CSUM_EN adds a trailing XOR checksum byte to the stream.
package fw_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_t;

    // A count of exactly 2**addr_w words fills the RAM and is still legal.
    function automatic logic len_overflow(input logic [15:0] len, input int unsigned addr_w);
        return {16'd0, len} > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/fw_word_packer.sv
// fw_word_packer: packs a byte stream into 32-bit little-endian words.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_clear         - drop any partially assembled word
//   i_byte          - incoming byte
//   i_strobe        - i_byte is accepted this cycle
//   o_word          - assembled word, valid together with o_word_valid
//   o_word_valid    - pulses in the cycle the last byte of a word is strobed
// The word is presented combinationally so the caller can register it into
// its write port on the same edge that accepts the final byte.
module fw_word_packer
    import fw_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_low;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= 2'd0;
            r_low <= 24'd0;
        end else if (i_strobe) begin
            r_cnt <= r_cnt + 2'd1;
            unique case (r_cnt)
                2'd0: r_low[7:0]   <= i_byte;
                2'd1: r_low[15:8]  <= i_byte;
                2'd2: r_low[23:16] <= i_byte;
                2'd3: ;  // top byte goes straight out on o_word
                default: ;
            endcase
        end
    end

    assign o_word       = {i_byte, r_low};
    assign o_word_valid = i_strobe && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/fw_loader.sv
// fw_loader: run-time firmware loader for the core RAM.
// Holds the core in reset, receives LEN_LO, LEN_HI (word count N), 4*N payload
// bytes and, when built with LOADER_CSUM_EN, a trailing XOR checksum byte.
// Payload is written little-endian to consecutive word addresses from 0; the
// core is released only once the whole image is in RAM and accepted.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_in_data       - stream byte
//   i_in_valid      - i_in_data valid
//   o_in_ready      - loader accepts a byte this cycle
//   o_mem_we        - one-cycle RAM word write strobe
//   o_mem_addr      - RAM word address
//   o_mem_wdata     - RAM write word
//   o_core_resetn   - active-low core reset, released after a good load
//   o_done          - image loaded (sticky until reset)
//   o_error         - image rejected (sticky until reset)
// Build option: define LOADER_CSUM_EN to require and check the checksum byte.
module fw_loader
    import fw_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_core_resetn,
    output logic              o_done,
    output logic              o_error
);

`ifdef LOADER_CSUM_EN
    localparam state_t StAfterData = StCsum;
`else
    localparam state_t StAfterData = StDone;
`endif

    state_t            r_state;
    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_widx;  // one extra bit so N = 2**ADDR_W can be counted
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_resetn;
    logic              r_done;
    logic              r_error;
`ifdef LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_last_word;
    logic [31:0] w_word;
    logic        w_word_valid;

    assign o_in_ready  = (r_state != StDone) && (r_state != StErr);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_len_full  = {i_in_data, r_len[7:0]};
    assign w_last_word = (32'(r_widx) + 32'd1) == {16'd0, r_len};

    fw_word_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (r_state != StData),
        .i_byte       (i_in_data),
        .i_strobe     (w_accept && (r_state == StData)),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StLen0;
            r_len         <= 16'd0;
            r_widx        <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= 32'd0;
            r_core_resetn <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
`ifdef LOADER_CSUM_EN
            r_csum        <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_word_valid) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_widx[ADDR_W-1:0];
                r_mem_wdata <= w_word;
                r_widx      <= r_widx + {{ADDR_W{1'b0}}, 1'b1};
            end

            unique case (r_state)
                StLen0: begin
                    if (w_accept) begin
                        r_len[7:0] <= i_in_data;
                        r_state    <= StLen1;
                    end
                end
                StLen1: begin
                    if (w_accept) begin
                        r_len[15:8] <= i_in_data;
                        if (len_overflow(w_len_full, ADDR_W)) begin
                            r_state <= StErr;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= StAfterData;
                        end else begin
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
`ifdef LOADER_CSUM_EN
                    if (w_accept) begin
                        r_csum <= r_csum ^ i_in_data;
                    end
`endif
                    if (w_word_valid && w_last_word) begin
                        r_state <= StAfterData;
                    end
                end
                StCsum: begin
`ifdef LOADER_CSUM_EN
                    if (w_accept) begin
                        r_state <= (i_in_data == r_csum) ? StDone : StErr;
                    end
`else
                    r_state <= StErr;  // unreachable without the checksum option
`endif
                end
                StDone: begin
                    r_done        <= 1'b1;
                    r_core_resetn <= 1'b1;
                end
                StErr: begin
                    r_error <= 1'b1;
                end
                default: r_state <= StErr;
            endcase
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_core_resetn = r_core_resetn;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_fw_loader.sv
// tb_fw_loader: directed bench for fw_loader.
// Two instances share one input stream: ADDR_W=4 (always checked) and the
// default ADDR_W=12 (checked whenever the length fits both). A stream-level
// model derives every output per cycle from the byte index of each accepted
// byte; literal expectations pin the model on the key scenarios.
module tb_fw_loader;

    localparam int unsigned AW = 4;
`ifdef LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;

    logic        rdy4, we4, crn4, done4, err4;
    logic [3:0]  addr4;
    logic [31:0] wd4;
    logic        rdy12, we12, crn12, done12, err12;
    logic [11:0] addr12;
    logic [31:0] wd12;

    fw_loader #(.ADDR_W(AW)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(rdy4), .o_mem_we(we4), .o_mem_addr(addr4), .o_mem_wdata(wd4),
        .o_core_resetn(crn4), .o_done(done4), .o_error(err4)
    );

    fw_loader u_dut12 (
        .i_clk(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(rdy12), .o_mem_we(we12), .o_mem_addr(addr12), .o_mem_wdata(wd12),
        .o_core_resetn(crn12), .o_done(done12), .o_error(err12)
    );

    int n_checks = 0;
    int n_err = 0;

    int cyc = 0;
    bit live = 1'b0;
    bit rst_cap = 1'b0;
    bit chk12 = 1'b1;

    // Stream model: age counts edges since the final byte was accepted (-1: not yet).
    int          age = -1;
    bit          m_ok = 1'b0;
    int          m_idx = 0;
    int          m_len = 0;
    logic [31:0] m_word = 32'd0;
    logic [7:0]  m_xor = 8'd0;
    bit          pend_we = 1'b0;
    int          pend_addr = 0;
    logic [31:0] pend_data = 32'd0;
    bit          exp_we = 1'b0;
    int          exp_addr = 0;
    logic [31:0] exp_data = 32'd0;

    int          term_cyc = -1;
    int          done_cyc = -1;
    bit          done_prev = 1'b0;
    int          wr_cnt = 0;
    logic [31:0] mem_rec [16];
    logic [7:0]  stream [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_dut(input string p, input logic rdy, we, input logic [31:0] addr, wd,
                           input logic crn, dn, er);
        bit fin;
        fin = (age >= 2);
        chk({p, ".in_ready"}, 32'(rdy), 32'(age < 1));
        chk({p, ".mem_we"}, 32'(we), 32'(exp_we));
        chk({p, ".mem_addr"}, addr, 32'(exp_addr));
        chk({p, ".mem_wdata"}, wd, exp_data);
        chk({p, ".core_resetn"}, 32'(crn), 32'(fin && m_ok));
        chk({p, ".done"}, 32'(dn), 32'(fin && m_ok));
        chk({p, ".error"}, 32'(er), 32'(fin && !m_ok));
    endtask

    task automatic model_term(input bit ok);
        age = 0;
        m_ok = ok;
        term_cyc = cyc;
    endtask

    task automatic model_accept(input logic [7:0] b);
        int p;
        if (m_idx == 0) begin
            m_len = int'(b);
        end else if (m_idx == 1) begin
            m_len = m_len + (int'(b) << 8);
            if (m_len > (1 << AW)) model_term(1'b0);
            else if (m_len == 0 && !CSUM) model_term(1'b1);
        end else if (m_idx < 2 + 4 * m_len) begin
            p = m_idx - 2;
            m_word[(p % 4) * 8 +: 8] = b;
            m_xor = m_xor ^ b;
            if (p % 4 == 3) begin
                pend_we = 1'b1;
                pend_addr = p / 4;
                pend_data = m_word;
            end
            if (!CSUM && m_idx == 1 + 4 * m_len) model_term(1'b1);
        end else if (CSUM && m_idx == 2 + 4 * m_len) begin
            model_term(b == m_xor);
        end
        m_idx++;
    endtask

    // Compare process: everything is evaluated mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_cap) begin
            live = 1'b1;
            age = -1;
            m_ok = 1'b0;
            m_idx = 0;
            m_len = 0;
            m_word = 32'd0;
            m_xor = 8'd0;
            pend_we = 1'b0;
            exp_we = 1'b0;
            exp_addr = 0;
            exp_data = 32'd0;
        end else if (live) begin
            if (age >= 0) age++;
            exp_we = pend_we;
            if (pend_we) begin
                exp_addr = pend_addr;
                exp_data = pend_data;
            end
            pend_we = 1'b0;
        end
        if (live) begin
            chk_dut("w4", rdy4, we4, 32'(addr4), wd4, crn4, done4, err4);
            if (chk12) chk_dut("w12", rdy12, we12, 32'(addr12), wd12, crn12, done12, err12);
            if (we4 === 1'b1) begin
                wr_cnt++;
                mem_rec[addr4] = wd4;
            end
            if (done4 === 1'b1 && !done_prev) done_cyc = cyc;
            done_prev = (done4 === 1'b1);
            if (!rst && in_valid && age < 1) model_accept(in_data);
        end
        rst_cap = rst;
    end

    // All stimulus tasks start and end at posedge + #1.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        for (int g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            idle(1);
        end
        in_data = b;
        in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            got = (rdy4 === 1'b1);
            @(posedge clk);
            #1;
            if (got) break;
        end
        in_valid = 1'b0;
        in_data = 8'($urandom);
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL send: byte %02h not accepted within 8 cycles", b);
        end
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) send_byte(stream[i], int'($urandom_range(0, max_gap)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic new_test();
        wr_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < 16; i++) mem_rec[i] = 32'd0;
        stream.delete();
    endtask

    task automatic build_nominal(input logic [7:0] csum);
        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CSUM) stream.push_back(csum);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset.in_ready", 32'(rdy4), 32'd1);
        chk("reset.mem_we", 32'(we4), 32'd0);
        chk("reset.core_resetn", 32'(crn4), 32'd0);
        chk("reset.done", 32'(done4), 32'd0);

        // Nominal two-word image.
        new_test();
        build_nominal(8'h2A);
        send_stream(0);
        idle(4);
        chk("nom.mem0", mem_rec[0], 32'h12345678);
        chk("nom.mem1", mem_rec[1], 32'hDEADBEEF);
        chk("nom.writes", 32'(wr_cnt), 32'd2);
        chk("nom.done", 32'(done4), 32'd1);
        chk("nom.core_resetn", 32'(crn4), 32'd1);
        chk("nom.in_ready", 32'(rdy4), 32'd0);
        chk("nom.done_latency", 32'(done_cyc - term_cyc), 32'd2);
        in_data = 8'h55;
        in_valid = 1'b1;
        idle(3);
        in_valid = 1'b0;
        idle(2);
        chk("nom.ignored_after_done", 32'(wr_cnt), 32'd2);
        do_reset();

        // Bad checksum byte.
        new_test();
        build_nominal(8'h2B);
        send_stream(0);
        idle(4);
        chk("badcs.writes", 32'(wr_cnt), 32'd2);
        chk("badcs.error", 32'(err4), 32'(CSUM));
        chk("badcs.done", 32'(done4), 32'(!CSUM));
        chk("badcs.core_resetn", 32'(crn4), 32'(!CSUM));
        do_reset();

        // Empty image.
        new_test();
        stream = '{8'h00, 8'h00};
        if (CSUM) stream.push_back(8'h00);
        send_stream(0);
        idle(4);
        chk("empty.writes", 32'(wr_cnt), 32'd0);
        chk("empty.done", 32'(done4), 32'd1);
        do_reset();

        // Full RAM on the ADDR_W=4 instance: bytes 0..63.
        new_test();
        stream = '{8'h10, 8'h00};
        for (int k = 0; k < 64; k++) stream.push_back(8'(k));
        if (CSUM) stream.push_back(8'h00);
        send_stream(0);
        idle(4);
        chk("full.writes", 32'(wr_cnt), 32'd16);
        chk("full.mem0", mem_rec[0], 32'h03020100);
        chk("full.mem15", mem_rec[15], 32'h3F3E3D3C);
        chk("full.done", 32'(done4), 32'd1);
        do_reset();

        // One word too many: rejected right after LEN_HI (the 12-bit instance would accept it).
        new_test();
        chk12 = 1'b0;
        stream = '{8'h11, 8'h00};
        send_stream(0);
        idle(3);
        chk("ovf.writes", 32'(wr_cnt), 32'd0);
        chk("ovf.error", 32'(err4), 32'd1);
        chk("ovf.done", 32'(done4), 32'd0);
        chk("ovf.in_ready", 32'(rdy4), 32'd0);
        do_reset();
        chk12 = 1'b1;

        // Nominal image with random bubbles on in_valid.
        new_test();
        build_nominal(8'h2A);
        send_stream(3);
        idle(4);
        chk("bub.mem0", mem_rec[0], 32'h12345678);
        chk("bub.mem1", mem_rec[1], 32'hDEADBEEF);
        chk("bub.done_latency", 32'(done_cyc - term_cyc), 32'd2);
        do_reset();

        // Reset after six payload bytes, then a full reload.
        new_test();
        build_nominal(8'h2A);
        for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
        do_reset();
        idle(2);
        chk("midrst.writes", 32'(wr_cnt), 32'd1);
        chk("midrst.mem0", mem_rec[0], 32'h12345678);
        chk("midrst.core_resetn", 32'(crn4), 32'd0);
        send_stream(0);
        idle(4);
        chk("reload.writes", 32'(wr_cnt), 32'd3);
        chk("reload.mem1", mem_rec[1], 32'hDEADBEEF);
        chk("reload.done", 32'(done4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
